// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: operand/op request side and result/response side.
interface alu_mc_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [3:0]      instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, src_a, src_b, instr, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, src_a, src_b, instr, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/compare ops, iterative MUL/DIV/MOD.
// Define ALU_MC_FAST_MUL_EN to make MUL single-cycle (DIV/MOD stay iterative).
module alu_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0]       OP_MUL   = 4'hD;
    localparam logic [3:0]       OP_DIV   = 4'hE;
    localparam logic [3:0]       OP_MOD   = 4'hF;
    localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(XLEN);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [SHAMT_W:0]  count_q;
    logic [XLEN-1:0]   acc_q, opa_q, opb_q, result_q;
    logic              qneg_q, rneg_q, dz_q;

    logic [XLEN-1:0]   a, b, a_mag, b_mag, alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic              lt_s, lt_u, eq, is_iter;

    assign a     = bus.src_a;
    assign b     = bus.src_b;
    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;
    assign a_mag = a[XLEN-1] ? -a : a;
    assign b_mag = b[XLEN-1] ? -b : b;

`ifdef ALU_MC_FAST_MUL_EN
    assign is_iter = (bus.instr == OP_DIV) || (bus.instr == OP_MOD);
`else
    assign is_iter = bus.instr >= OP_MUL;
`endif

    always_comb begin
        alu_res = '0;
        case (bus.instr)
            4'h0: alu_res = a + b;
            4'h1: alu_res = a - b;
            4'h2: alu_res = a & b;
            4'h3: alu_res = a | b;
            4'h4: alu_res = a ^ b;
            4'h5: alu_res = a << shamt;
            4'h6: alu_res = XLEN'($signed(a) >>> shamt);
            4'h7: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            4'h8: alu_res = {{(XLEN-1){1'b0}}, eq};
            4'h9: alu_res = {{(XLEN-1){1'b0}}, ~eq};
            4'hA: alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
            4'hB: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            4'hC: alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
`ifdef ALU_MC_FAST_MUL_EN
            4'hD: alu_res = a * b;
`endif
            default: alu_res = '0;
        endcase
    end

    // One iteration: shift-add for MUL, restoring step on magnitudes for DIV/MOD.
    // opa_q holds multiplicand / dividend shifting into quotient; acc_q holds product / remainder.
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] acc_n, opa_n, opb_n, fin_res;

    assign rem_sh = {acc_q, opa_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, opb_q};

    always_comb begin
        acc_n = acc_q;
        opa_n = opa_q;
        opb_n = opb_q;
        if (op_q == OP_MUL) begin
            acc_n = acc_q + (opb_q[0] ? opa_q : '0);
            opa_n = opa_q << 1;
            opb_n = opb_q >> 1;
        end else begin
            acc_n = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
            opa_n = {opa_q[XLEN-2:0], ~trial[XLEN]};
        end
    end

    // A zero divisor yields all-ones quotient and |a| remainder, so only DIV needs patching.
    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:  fin_res = acc_n;
            OP_DIV:  fin_res = dz_q ? '1 : (qneg_q ? -opa_n : opa_n);
            default: fin_res = rneg_q ? -acc_n : acc_n;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = is_iter ? BUSY : DONE;
            BUSY:    if (count_q == CNT_ONE) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    op_q <= bus.instr;
                    if (is_iter) begin
                        count_q <= CNT_INIT;
                        acc_q   <= '0;
                        opa_q   <= (bus.instr == OP_MUL) ? a : a_mag;
                        opb_q   <= (bus.instr == OP_MUL) ? b : b_mag;
                        qneg_q  <= a[XLEN-1] ^ b[XLEN-1];
                        rneg_q  <= a[XLEN-1];
                        dz_q    <= b == '0;
                    end else begin
                        result_q <= alu_res;
                    end
                end
                BUSY: begin
                    acc_q   <= acc_n;
                    opa_q   <= opa_n;
                    opb_q   <= opb_n;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) result_q <= fin_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q == BUSY;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.zero      = result_q == '0;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, handshaked successor to the single-cycle combinational ALU in the execute stage.
- Keeps the same 4-bit op encoding, parametrised in XLEN.
- Adds a registered result and valid/ready handshakes on both sides.
- MUL/DIV/MOD run iteratively, with defined RISC-V divide-by-zero and overflow results, so no combinational divider sits in the execute critical path.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from src_b.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- src_a  in  XLEN  operand A, signed.
- src_b  in  XLEN  operand B, signed.
- instr  in  4  op code (encoding below).
- out_valid  out  1  result/zero valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  registered, =1 when result==0.
- busy  out  1  high in BUSY state.

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA.
  - 7 SLT (signed), 8 EQ, 9 NEQ, A GTE (signed), B LTU, C GEU.
  - D MUL (low XLEN bits), E DIV (signed), F MOD (signed remainder).
  - Compares return 1 or 0.
- Shifts use src_b[SHAMT_W-1:0] only; upper bits ignored (differs from predecessor).
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. in_valid=1 latches src_a, src_b and instr.
    - Ops 0-C: compute, register result, -> DONE.
    - Ops D-F: load datapath, count=XLEN, -> BUSY.
  - BUSY: one radix-2 step per cycle; count decrements. At count==1 the final step registers result, -> DONE.
  - DONE: out_valid=1; result/zero held stable. out_ready=1 -> IDLE (out_valid drops next cycle). No new accept in the DONE cycle.
- Latency, accept edge to out_valid=1:
  - Ops 0-C: 1 cycle.
  - Ops D-F: XLEN+1 cycles.
  - Throughput: at most one op per 2 cycles.
- MUL: shift-add on raw bits; low XLEN bits of the product, identical for signed and unsigned.
- DIV/MOD:
  - Restoring division on magnitudes; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Divide by zero: DIV = all ones (-1); MOD = src_a. Full XLEN iterations still run (latency constant).
  - Overflow, src_a = -2^(XLEN-1) and src_b = -1: DIV = src_a, MOD = 0.
- Inputs are ignored while not IDLE; operand changes during BUSY have no effect.
- Reset, including mid-BUSY: state=IDLE, result=0, zero=1, out_valid=0, busy=0, count=0. Any in-flight op is discarded.
- zero is derived from the registered result, never from the next-state value.

Optional Feature:
- Macro: ALU_MC_FAST_MUL_EN.
- Defined: MUL is single-cycle (combinational multiply registered at accept), latency 1. DIV/MOD unchanged.
- Undefined: MUL is iterative, latency XLEN+1 as above.
- Bench reads the macro and checks the matching latency.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> result=0x80000000, zero=0, out_valid exactly 1 cycle after accept.
- SUB 5-5 with out_ready held low 3 cycles -> result=0, zero=1; out_valid and result stable until out_ready; in_ready=0 throughout.
- SRA 0x80000000 by src_b=0x21 (amount 1) -> 0xC0000000. SLT -1 < 1 -> 1. LTU 0xFFFFFFFF < 1 -> 0.
- MUL -3*7 -> 0xFFFFFFEB:
  - Without macro: out_valid 33 cycles after accept, busy high 32 cycles.
  - With macro: 1 cycle.
- DIV -7/2 -> 0xFFFFFFFD; MOD -7%2 -> 0xFFFFFFFF; DIV 9/0 -> 0xFFFFFFFF; MOD 9%0 -> 9; DIV 0x80000000/-1 -> 0x80000000; MOD of the same -> 0, zero=1.
- Assert rst at BUSY cycle 10 of a DIV -> outputs at reset values immediately. After release: in_ready=1 next cycle; next ADD 2+2 -> 4 with correct 1-cycle latency.
